pixel_frame_gen: RTL and testbench

Raster pixel source feeding the ILI9341 SPI controller: replaces the flat-colour frame fill with a full frame containing a mood-coloured background and a centred "face" sprite (box plus two eyes). Sits directly upstream of the controller, answers its per-pixel data requests, and raises `frame_done` when the last pixel of a frame has been delivered. A change of the `visua` mood code triggers a redraw at the next frame boundary.

---
 rtl/pixel_frame_gen.sv | 97 +++++++++
 tb/tb_pixel_frame_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pixel_frame_gen.sv
// pixel_frame_gen: raster pixel source with mood background and centred face sprite
module pixel_frame_gen #(
  parameter int H_RES = 240,
  parameter int V_RES = 320,
  parameter int PIXEL_SIZE = 16,
  parameter int BOX = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            visua,
  input  logic                  refresh,
  input  logic                  pixel_req,
  output logic [PIXEL_SIZE-1:0] pixel_data,
  output logic                  frame_done
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW:0] X0 = (XW+1)'((H_RES - BOX) / 2);
  localparam logic [XW:0] XB = (XW+1)'(BOX);
  localparam logic [XW:0] XL = (XW+1)'(BOX / 4);
  localparam logic [XW:0] XR = (XW+1)'(5 * BOX / 8);
  localparam logic [XW:0] XE = (XW+1)'(BOX / 8);
  localparam logic [YW:0] Y0 = (YW+1)'((V_RES - BOX) / 2);
  localparam logic [YW:0] YB = (YW+1)'(BOX);
  localparam logic [YW:0] YQ = (YW+1)'(BOX / 4);
  localparam logic [YW:0] YE = (YW+1)'(BOX / 8);
  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;
  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [3:0]            mood_q, mood_d;
  logic                  pend_q, pend_d;
  logic [PIXEL_SIZE-1:0] pix_q, pix_d;
  logic [XW:0]           dx;
  logic [YW:0]           dy;
  logic                  box, eye, last_x, last_y;
  logic [15:0]           bg, col;
  always_comb begin
    dx = {1'b0, x_q} - X0;
    dy = {1'b0, y_q} - Y0;
    box = dx < XB && dy < YB;
    eye = (dy - YQ) < YE && ((dx - XL) < XE || (dx - XR) < XE);
    bg = mood_q == 4'd0 ? 16'hFFE0 :
         mood_q == 4'd1 ? 16'h07FF :
         mood_q == 4'd2 ? 16'hF800 :
         mood_q == 4'd3 ? 16'h780F :
         mood_q == 4'd4 ? 16'h0000 : 16'h001F;
    col = eye ? (mood_q == 4'd4 ? 16'hFFFF : 16'h0000) :
          box ? (mood_q == 4'd4 ? 16'h8410 : 16'hFFFF) : bg;
    last_x = x_q == XW'(H_RES - 1);
    last_y = y_q == YW'(V_RES - 1);
  end
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    mood_d = mood_q;
    pix_d = pix_q;
    pend_d = pend_q | refresh;
    case (state_q)
      LOAD: begin
        mood_d = visua;
        x_d = '0;
        y_d = '0;
        pend_d = refresh;
        state_d = STREAM;
      end
      STREAM: if (pixel_req) begin
        pix_d = PIXEL_SIZE'(col);
        x_d = last_x ? '0 : x_q + 1'b1;
        y_d = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
        state_d = last_x && last_y ? DONE : STREAM;
      end
      DONE: state_d = (visua != mood_q || pend_q || refresh) ? LOAD : DONE;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      x_q <= '0;
      y_q <= '0;
      mood_q <= '0;
      pend_q <= 1'b0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      mood_q <= mood_d;
      pend_q <= pend_d;
      pix_q <= pix_d;
    end
  end
  assign pixel_data = pix_q;
  assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_pixel_frame_gen.sv
// tb_pixel_frame_gen: randomized self-checking bench for pixel_frame_gen
module tb_pixel_frame_gen;
  localparam int H = 48;
  localparam int V = 40;
  localparam int B = 16;
  localparam int PS = 16;
  localparam int N = H * V;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    visua = 4'd1;
  logic          refresh = 1'b0;
  logic          pixel_req = 1'b0;
  logic [PS-1:0] pixel_data;
  logic          frame_done;
  logic [15:0]   exp_pix = 16'h0000;
  int            total = 0;
  int            bad = 0;
  int            rv;
  always #5 clk = ~clk;
  pixel_frame_gen #(.H_RES(H), .V_RES(V), .PIXEL_SIZE(PS), .BOX(B)) dut (
    .clk(clk),
    .rst(rst),
    .visua(visua),
    .refresh(refresh),
    .pixel_req(pixel_req),
    .pixel_data(pixel_data),
    .frame_done(frame_done)
  );
  function automatic logic [15:0] model(input int x, input int y, input int m);
    int x0, y0, e;
    bit in_box, in_eye;
    logic [15:0] bg;
    x0 = (H - B) / 2;
    y0 = (V - B) / 2;
    e = B / 8;
    in_box = x >= x0 && x < x0 + B && y >= y0 && y < y0 + B;
    in_eye = y >= y0 + B / 4 && y < y0 + B / 4 + e &&
             ((x >= x0 + B / 4 && x < x0 + B / 4 + e) ||
              (x >= x0 + 5 * B / 8 && x < x0 + 5 * B / 8 + e));
    case (m)
      0: bg = 16'hFFE0;
      1: bg = 16'h07FF;
      2: bg = 16'hF800;
      3: bg = 16'h780F;
      4: bg = 16'h0000;
      default: bg = 16'h001F;
    endcase
    if (in_eye) return m == 4 ? 16'hFFFF : 16'h0000;
    if (in_box) return m == 4 ? 16'h8410 : 16'hFFFF;
    return bg;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n, input logic fd_exp, input logic req);
    for (int k = 0; k < n; k++) begin
      pixel_req = req;
      @(negedge clk);
      chk("idle_pix", 32'(pixel_data), 32'(exp_pix));
      chk("idle_fd", 32'(frame_done), 32'(fd_exp));
    end
    pixel_req = 1'b0;
  endtask
  task automatic stream(input int m, input int maxgap, input int stop, input int chg_at,
                        input logic [3:0] chg_v, input int r1, input int r2);
    for (int i = 0; i < stop; i++) begin
      if (i == chg_at) visua = chg_v;
      for (int g = $urandom_range(0, maxgap); g > 0; g--) begin
        pixel_req = 1'b0;
        @(negedge clk);
        chk("gap_hold", 32'(pixel_data), 32'(exp_pix));
        chk("gap_fd", 32'(frame_done), 32'd0);
      end
      pixel_req = 1'b1;
      refresh = (i == r1 || i == r2);
      @(negedge clk);
      pixel_req = 1'b0;
      refresh = 1'b0;
      exp_pix = model(i % H, i / H, m);
      chk("pix", 32'(pixel_data), 32'(exp_pix));
      chk("fd", 32'(frame_done), 32'(i == N - 1));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'(pixel_data), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    idle(1, 1'b0, 1'b0);
    stream(1, 0, N, -1, 4'd0, -1, -1);
    idle(3, 1'b1, 1'b1);
    visua = 4'd4;
    idle(2, 1'b0, 1'b1);
    stream(4, 0, N, -1, 4'd0, -1, -1);
    visua = 4'd0;
    idle(2, 1'b0, 1'b0);
    stream(0, 0, N, 1000, 4'd2, -1, -1);
    idle(2, 1'b0, 1'b1);
    stream(2, 0, N, -1, 4'd0, -1, -1);
    idle(5, 1'b1, 1'b1);
    visua = 4'd1;
    idle(2, 1'b0, 1'b0);
    stream(1, 12, N, -1, 4'd0, -1, -1);
    idle(2, 1'b1, 1'b0);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    chk("rfr_done_fd", 32'(frame_done), 32'd0);
    idle(1, 1'b0, 1'b1);
    stream(1, 0, N, -1, 4'd0, 100, 900);
    idle(2, 1'b0, 1'b0);
    stream(1, 0, N, -1, 4'd0, -1, -1);
    idle(5, 1'b1, 1'b0);
    rv = $urandom_range(5, 15);
    visua = 4'(rv);
    idle(2, 1'b0, 1'b1);
    stream(rv, 3, 700, -1, 4'd0, -1, -1);
    rst = 1'b1;
    pixel_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pixel_req = 1'b0;
    visua = 4'd7;
    exp_pix = 16'h0000;
    chk("midrst_pix", 32'(pixel_data), 32'd0);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    idle(1, 1'b0, 1'b0);
    stream(7, 0, N, -1, 4'd0, -1, -1);
    idle(2, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
